// File: rtl/decoder_func_unit.sv
// Two-stage valid/ready decoder: an IN_W-bit value becomes one-hot minterms, and NUM_F
// runtime-programmable sum-of-minterms functions are evaluated from them.
module decoder_func_unit #(
  parameter int unsigned                IN_W       = 3,
  parameter int unsigned                NUM_F      = 3,
  parameter logic [NUM_F*(2**IN_W)-1:0] INIT_MASKS = 24'h9C0994,
  parameter int unsigned                SEL_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_F-1:0]     out_f,
  output logic [(2**IN_W)-1:0] out_onehot,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [SEL_W-1:0]     cfg_sel,
  input  logic [(2**IN_W)-1:0] cfg_mask,
  output logic                 cfg_err
);

  localparam int unsigned MT = 2**IN_W;

  logic [NUM_F-1:0][MT-1:0] mask_q, mask_d;
  logic                     s1_v_q, s1_v_d;
  logic [MT-1:0]            s1_onehot_q, s1_onehot_d;
  logic                     out_valid_q, out_valid_d;
  logic [NUM_F-1:0]         out_f_q, out_f_d;
  logic [MT-1:0]            out_onehot_q, out_onehot_d;
  logic                     cfg_err_q, cfg_err_d;

  logic s2_free, s1_adv, s1_free, cfg_acc, in_acc;

  // Handshake network; a mask write only goes through with both stages empty.
  always_comb begin
    s2_free = !out_valid_q || out_ready;
    s1_adv  = s1_v_q && s2_free;
    s1_free = !s1_v_q || s1_adv;
    cfg_acc = cfg_valid && !s1_v_q && !out_valid_q;
    in_acc  = in_valid && s1_free && !cfg_acc;
  end

  assign in_ready   = s1_free && !cfg_acc;
  assign cfg_ready  = cfg_acc;
  assign out_valid  = out_valid_q;
  assign out_f      = out_f_q;
  assign out_onehot = out_onehot_q;
  assign cfg_err    = cfg_err_q;

  // Next-state for both pipeline stages and the mask table.
  always_comb begin
    s1_v_d       = s1_v_q;
    s1_onehot_d  = s1_onehot_q;
    out_valid_d  = out_valid_q;
    out_f_d      = out_f_q;
    out_onehot_d = out_onehot_q;
    mask_d       = mask_q;
    cfg_err_d    = 1'b0;

    if (s1_adv) begin
      s1_v_d = 1'b0;
    end
    if (in_acc) begin
      s1_v_d      = 1'b1;
      s1_onehot_d = MT'(1) << in_data;
    end

    if (s1_adv) begin
      out_valid_d  = 1'b1;
      out_onehot_d = s1_onehot_q;
      for (int i = 0; i < NUM_F; i++) begin
        out_f_d[i] = |(s1_onehot_q & mask_q[i]);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Out-of-range selects match no entry and only raise the error pulse.
    for (int i = 0; i < NUM_F; i++) begin
      if (cfg_acc && (cfg_sel == SEL_W'(i))) begin
        mask_d[i] = cfg_mask;
      end
    end
    cfg_err_d = cfg_acc && (32'(cfg_sel) >= NUM_F);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q       <= INIT_MASKS;
      s1_v_q       <= 1'b0;
      s1_onehot_q  <= '0;
      out_valid_q  <= 1'b0;
      out_f_q      <= '0;
      out_onehot_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      s1_v_q       <= s1_v_d;
      s1_onehot_q  <= s1_onehot_d;
      out_valid_q  <= out_valid_d;
      out_f_q      <= out_f_d;
      out_onehot_q <= out_onehot_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_decoder_func_unit.sv
// Scoreboard bench for decoder_func_unit: default 3-in/3-function build plus a
// 4-in/5-function build with all-zero reset masks.
module tb_decoder_func_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic       cfg_valid, cfg_ready, cfg_err;
  logic [2:0] in_data, out_f;
  logic [7:0] out_onehot, cfg_mask;
  logic [1:0] cfg_sel;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic        p_cfg_valid, p_cfg_ready, p_cfg_err;
  logic [3:0]  p_in_data;
  logic [4:0]  p_out_f;
  logic [15:0] p_out_onehot, p_cfg_mask;
  logic [2:0]  p_cfg_sel;

  decoder_func_unit #(.IN_W(3), .NUM_F(3), .INIT_MASKS(24'h9C0994), .SEL_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_onehot(out_onehot),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_mask(cfg_mask),
    .cfg_err(cfg_err)
  );

  decoder_func_unit #(.IN_W(4), .NUM_F(5), .INIT_MASKS(80'h0), .SEL_W(3)) dut_p (
    .clk(clk), .rst(rst),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_f(p_out_f),
    .out_onehot(p_out_onehot),
    .cfg_valid(p_cfg_valid), .cfg_ready(p_cfg_ready), .cfg_sel(p_cfg_sel),
    .cfg_mask(p_cfg_mask), .cfg_err(p_cfg_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [10:0] sb[$];
  logic [20:0] sb2[$];
  logic [7:0]  m[3];

  task automatic set_init_masks;
    m[0] = 8'h94;
    m[1] = 8'h09;
    m[2] = 8'h9C;
  endtask

  // Reference: f_i is simply bit d of mask i.
  function automatic logic [10:0] model(input logic [2:0] d);
    logic [2:0] f;
    logic [7:0] oh;
    for (int i = 0; i < 3; i++) f[i] = m[i][d];
    oh = 8'd1 << d;
    return {f, oh};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_f !== 3'b000) begin n_fail++; $display("FAIL reset_out_f: got %b want 000", out_f); end
    n_cmp++; if (out_onehot !== 8'h00) begin n_fail++; $display("FAIL reset_onehot: got %h want 00", out_onehot); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (p_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_out_valid: got %b want 0", p_out_valid); end
    tick();
  endtask

  task automatic test_defaults;
    logic [10:0] exp;
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 8); in_data = 3'(c); out_ready = 1'b1;
      #3;
      n_cmp++;
      if (out_valid !== ((c >= 2) && (c < 10))) begin
        n_fail++; $display("FAIL defaults_latency c=%0d: out_valid %b want %b", c, out_valid, (c >= 2) && (c < 10));
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL defaults_extra: f=%b oh=%h", out_f, out_onehot); end
        else begin
          exp = sb.pop_front();
          if ({out_f, out_onehot} !== exp) begin
            n_fail++; $display("FAIL defaults_data: got f=%b oh=%h want f=%b oh=%h", out_f, out_onehot, exp[10:8], exp[7:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      tick();
    end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL defaults_lost: %0d results missing, want 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    logic [10:0] exp;
    logic [2:0]  bp[3];
    int          idx;
    bp[0] = 3'd2; bp[1] = 3'd3; bp[2] = 3'd4;
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? bp[idx] : 3'd0;
      out_ready = (c >= 4);
      #3;
      if (c == 2 || c == 3) begin
        n_cmp++; if (out_valid !== 1'b1 || out_f !== 3'b101 || out_onehot !== 8'h04) begin
          n_fail++; $display("FAIL bp_hold c=%0d: v=%b f=%b oh=%h want v=1 f=101 oh=04", c, out_valid, out_f, out_onehot);
        end
        n_cmp++; if (in_ready !== 1'b0 || idx != 2) begin
          n_fail++; $display("FAIL bp_stall c=%0d: in_ready=%b accepts=%0d want 0/2", c, in_ready, idx);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra: f=%b oh=%h", out_f, out_onehot); end
        else begin
          exp = sb.pop_front();
          if ({out_f, out_onehot} !== exp) begin
            n_fail++; $display("FAIL bp_data: got f=%b oh=%h want f=%b oh=%h", out_f, out_onehot, exp[10:8], exp[7:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        idx++;
      end
      tick();
    end
    n_cmp++; if (sb.size() != 0 || idx != 3) begin n_fail++; $display("FAIL bp_lost: pending=%0d accepts=%0d want 0/3", sb.size(), idx); end
  endtask

  task automatic test_cfg_drain;
    logic [10:0] exp;
    int waited;
    bit done;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_data = (c == 0) ? 3'd5 : 3'd6;
      #3;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL cfg_extra: f=%b", out_f); end
        else begin exp = sb.pop_front(); if ({out_f, out_onehot} !== exp) begin n_fail++; $display("FAIL cfg_pre: got f=%b want f=%b", out_f, exp[10:8]); end end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      tick();
    end
    in_valid = 1'b0; cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_mask = 8'h80;
    waited = 0; done = 1'b0;
    while (!done && waited < 8) begin
      #3;
      if (cfg_ready) begin
        done = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || waited != 2) begin
          n_fail++; $display("FAIL cfg_gate: out_valid=%b in_ready=%b wait=%0d want 0/0/2", out_valid, in_ready, waited);
        end
        m[1] = cfg_mask;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL cfg_extra: f=%b", out_f); end
        else begin exp = sb.pop_front(); if ({out_f, out_onehot} !== exp) begin n_fail++; $display("FAIL cfg_drain: got f=%b want f=%b", out_f, exp[10:8]); end end
      end
      tick();
      waited++;
    end
    cfg_valid = 1'b0;
    if (!done) begin n_cmp++; n_fail++; $display("FAIL cfg_timeout: cfg_ready %b after %0d cycles, want 1", cfg_ready, waited); end
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 2); in_data = (c == 0) ? 3'd7 : 3'd0;
      #3;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL cfg_extra: f=%b", out_f); end
        else begin exp = sb.pop_front(); if ({out_f, out_onehot} !== exp) begin n_fail++; $display("FAIL cfg_newmask: got f=%b oh=%h want f=%b oh=%h", out_f, out_onehot, exp[10:8], exp[7:0]); end end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      tick();
    end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL cfg_lost: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_bad_sel;
    logic [10:0] exp;
    in_valid = 1'b0; out_ready = 1'b1;
    cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_mask = 8'hFF;
    #3;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL badsel_ready: got %b want 1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    #3;
    n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL badsel_err: got %b want 1", cfg_err); end
    tick();
    #3;
    n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL badsel_pulse: got %b want 0", cfg_err); end
    tick();
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8); in_data = 3'(c);
      #3;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL badsel_extra: f=%b", out_f); end
        else begin exp = sb.pop_front(); if ({out_f, out_onehot} !== exp) begin n_fail++; $display("FAIL badsel_data: got f=%b oh=%h want f=%b oh=%h", out_f, out_onehot, exp[10:8], exp[7:0]); end end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      tick();
    end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL badsel_lost: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_mid_reset;
    logic [10:0] exp;
    in_valid = 1'b0; out_ready = 1'b1;
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_mask = 8'h01;
    #3;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
    m[0] = cfg_mask;
    tick();
    cfg_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 3'(c + 1);
      #3;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rst_extra: f=%b", out_f); end
        else begin exp = sb.pop_front(); if ({out_f, out_onehot} !== exp) begin n_fail++; $display("FAIL rst_pre: got f=%b want f=%b", out_f, exp[10:8]); end end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    sb.delete();
    set_init_masks();
    for (int c = 0; c < 3; c++) begin
      #3;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale c=%0d: out_valid=%b f=%b want 0", c, out_valid, out_f); end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0); in_data = 3'd2;
      #3;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_f[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mask_restore: f0=%b want 1", out_f[0]); end
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rst_extra: f=%b", out_f); end
        else begin exp = sb.pop_front(); if ({out_f, out_onehot} !== exp) begin n_fail++; $display("FAIL rst_post: got f=%b want f=%b", out_f, exp[10:8]); end end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      tick();
    end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL rst_lost: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_random;
    logic [10:0] exp;
    for (int c = 0; c < 70; c++) begin
      in_valid  = (c < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 3'($urandom_range(0, 7));
      out_ready = (c < 60) ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rand_extra: f=%b", out_f); end
        else begin exp = sb.pop_front(); if ({out_f, out_onehot} !== exp) begin n_fail++; $display("FAIL rand_data c=%0d: got f=%b oh=%h want f=%b oh=%h", c, out_f, out_onehot, exp[10:8], exp[7:0]); end end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      tick();
    end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_lost: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_param_sweep;
    logic [20:0] exp;
    logic [4:0]  f;
    logic [15:0] oh;
    p_out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        p_cfg_valid = 1'b1; p_cfg_sel = 3'd4; p_cfg_mask = 16'h8001;
        #3;
        n_cmp++; if (p_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_cfg_ready: got %b want 1", p_cfg_ready); end
        tick();
        p_cfg_valid = 1'b0;
        #3;
        n_cmp++; if (p_cfg_err !== 1'b0) begin n_fail++; $display("FAIL sweep_cfg_err: got %b want 0", p_cfg_err); end
        tick();
      end
      for (int c = 0; c < 18; c++) begin
        p_in_valid = (c < 16); p_in_data = 4'(c);
        #3;
        if (p_out_valid && p_out_ready) begin
          n_cmp++;
          if (sb2.size() == 0) begin n_fail++; $display("FAIL sweep_extra: f=%b", p_out_f); end
          else begin
            exp = sb2.pop_front();
            if ({p_out_f, p_out_onehot} !== exp) begin
              n_fail++; $display("FAIL sweep_data pass=%0d: got f=%b oh=%h want f=%b oh=%h", pass, p_out_f, p_out_onehot, exp[20:16], exp[15:0]);
            end
          end
        end
        if (p_in_valid && p_in_ready) begin
          f  = ((pass == 1) && (p_in_data == 4'd0 || p_in_data == 4'd15)) ? 5'b10000 : 5'b00000;
          oh = 16'd1 << p_in_data;
          sb2.push_back({f, oh});
        end
        tick();
      end
      n_cmp++; if (sb2.size() != 0) begin n_fail++; $display("FAIL sweep_lost: %0d pending want 0", sb2.size()); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_valid = 1'b0; cfg_sel = '0; cfg_mask = '0;
    p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
    p_cfg_valid = 1'b0; p_cfg_sel = '0; p_cfg_mask = '0;
    set_init_masks();
    test_reset();
    test_defaults();
    test_backpressure();
    test_cfg_drain();
    test_bad_sel();
    test_mid_reset();
    test_random();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
